// File: rtl/axi_tx_arbiter.sv
// axi_tx_arbiter: frame-granular arbiter that shares one AXI-stream input
// between NUM_SRC frame sources. A grant is locked from the first beat to
// the beat carrying last, beats are forwarded through one register stage,
// and the inter-frame idle gap is 1 cycle (single-lane) or 2 cycles (multi-lane).
// Optional build macro: ARB_STRICT_PRIO_EN selects fixed lowest-index priority
// instead of round-robin.
`ifndef AXI_DATA_SIZE
`define AXI_DATA_SIZE 64
`endif

module axi_tx_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = `AXI_DATA_SIZE
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             single_lane,
    input  logic [NUM_SRC-1:0]               src_valid,
    input  logic [NUM_SRC-1:0]               src_last,
    input  logic [NUM_SRC-1:0][DATA_W-1:0]   src_data,
    output logic [NUM_SRC-1:0]               src_ready,
    output logic                             axi_valid,
    output logic                             axi_last,
    output logic [DATA_W-1:0]                axi_data,
    output logic [$clog2(NUM_SRC)-1:0]       grant_id,
    output logic                             busy
);

    localparam int GW = $clog2(NUM_SRC);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t              r_state;
    logic [GW-1:0]       r_grant_id;
    logic                r_axi_valid;
    logic                r_axi_last;
    logic [DATA_W-1:0]   r_axi_data;

    logic                w_any_req;
    logic [GW-1:0]       w_winner;
    logic                w_accept;
    logic                w_sel_last;
    logic [DATA_W-1:0]   w_sel_data;

`ifndef ARB_STRICT_PRIO_EN
    logic [GW-1:0]       r_last_grant;
    logic [GW:0]         w_sum;
    logic [GW-1:0]       w_idx;
    logic                w_found;
`endif

    assign w_any_req  = |src_valid;
    assign w_accept   = (r_state == S_XFER) && src_valid[r_grant_id];
    assign w_sel_last = src_last[r_grant_id];
    assign w_sel_data = src_data[r_grant_id];

`ifdef ARB_STRICT_PRIO_EN
    // Fixed priority: the lowest requesting index wins.
    always_comb begin
        w_winner = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_valid[i]) w_winner = GW'(i);
        end
    end
`else
    // Round-robin: scan from last_grant+1 upward, wrapping at NUM_SRC.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_sum    = '0;
        w_idx    = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_sum = {1'b0, r_last_grant} + (GW+1)'(k);
            if (w_sum >= (GW+1)'(NUM_SRC)) w_sum = w_sum - (GW+1)'(NUM_SRC);
            w_idx = w_sum[GW-1:0];
            if (!w_found && src_valid[w_idx]) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end
`endif

    // Ready is only ever offered to the locked source while a frame is open.
    always_comb begin
        src_ready = '0;
        if (r_state == S_XFER) src_ready[r_grant_id] = 1'b1;
    end

    // Arbitration FSM with the registered output beat stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_grant_id  <= '0;
            r_axi_valid <= 1'b0;
            r_axi_last  <= 1'b0;
            r_axi_data  <= '0;
`ifndef ARB_STRICT_PRIO_EN
            r_last_grant <= GW'(NUM_SRC - 1);
`endif
        end else begin
            r_axi_valid <= 1'b0;
            r_axi_last  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_grant_id <= w_winner;
`ifndef ARB_STRICT_PRIO_EN
                        r_last_grant <= w_winner;
`endif
                        r_state <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (w_accept) begin
                        r_axi_valid <= 1'b1;
                        r_axi_last  <= w_sel_last;
                        r_axi_data  <= w_sel_data;
                        if (w_sel_last) r_state <= single_lane ? S_IDLE : S_GAP;
                    end
                end
                S_GAP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign axi_valid = r_axi_valid;
    assign axi_last  = r_axi_last;
    assign axi_data  = r_axi_data;
    assign grant_id  = r_grant_id;
    assign busy      = (r_state != S_IDLE);

endmodule
